data_mem_controller: RTL and testbench

- Responder side of the pipeline's memory-access interface.
- Accepts one load/store request at a time, encoded with the shared MEM_* width codes, over a valid/ready handshake.
- Services the request against an internal word-wide, synchronous-read data array.
- Performs byte-lane extraction, sign/zero extension and read-modify-write for sub-word stores.
- Returns a single-cycle response pulse to the MEM stage.

---
 rtl/data_mem_controller_pkg.sv | 35 +++
 rtl/data_mem_controller_byte_lane.sv | 39 +++
 rtl/data_mem_controller.sv | 134 +++++++++++++
 tb/tb_data_mem_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_controller_pkg.sv
// Shared definitions for the data memory controller: memory width codes,
// controller state encoding and the request legality check.
package data_mem_controller_pkg;

    localparam logic [2:0] MEM_BYTE              = 3'b000;
    localparam logic [2:0] MEM_HALFWORD          = 3'b001;
    localparam logic [2:0] MEM_WORD              = 3'b010;
    localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
    localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_READ,
        DMEM_WRITE,
        DMEM_RESP
    } dmem_state_t;

    // Flags misaligned accesses, unused codes and stores with an unsigned code.
    function automatic logic dmem_req_error(input logic       write,
                                            input logic [2:0] ctrl,
                                            input logic [1:0] addr_lo);
        logic err;
        case (ctrl)
            MEM_BYTE, MEM_BYTE_UNSIGNED:         err = 1'b0;
            MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: err = addr_lo[0];
            MEM_WORD:                            err = (addr_lo != 2'b00);
            default:                             err = 1'b1;
        endcase
        if (write && ctrl[2]) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/data_mem_controller_byte_lane.sv
// Combinational lane logic: formats load data from a stored word and merges
// sub-word store data into the old word for read-modify-write.
module dmem_byte_lane
    import data_mem_controller_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_ctrl,
    output logic [31:0] merged_word,
    output logic [31:0] load_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = old_word[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        merged_word = old_word;
        load_word   = old_word;
        case (mem_ctrl)
            MEM_BYTE: begin
                load_word = {{24{byte_sel[7]}}, byte_sel};
                merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            end
            MEM_BYTE_UNSIGNED: load_word = {24'b0, byte_sel};
            MEM_HALFWORD: begin
                load_word = {{16{half_sel[15]}}, half_sel};
                merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            end
            MEM_HALFWORD_UNSIGNED: load_word = {16'b0, half_sel};
            MEM_WORD: merged_word = store_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_controller.sv
// Load/store responder: one request at a time over valid/ready, serviced
// against a synchronous-read word array, single-cycle response pulse.
module data_mem_controller
    import data_mem_controller_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int INDEX_W     = $clog2(DEPTH_WORDS)
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_WData,
    input  logic [2:0]  Req_Mem_Ctrl,
    output logic        Resp_Valid,
    output logic [31:0] Resp_RData,
    output logic        Resp_Error
);

    dmem_state_t        state_q, state_d;
    logic               write_q, write_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [1:0]         lo_q, lo_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [31:0]        wword_q, wword_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        rd_word_q;
    logic               req_err;
    logic               rd_en;
    logic               mem_we;
    logic [31:0]        merged_word;
    logic [31:0]        load_word;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^Req_Addr[31:INDEX_W+2];

    assign Req_Ready  = (state_q == DMEM_IDLE);
    assign Resp_Valid = (state_q == DMEM_RESP);
    assign Resp_RData = rdata_q;
    assign Resp_Error = err_q;

    assign req_err = dmem_req_error(Req_Write, Req_Mem_Ctrl, Req_Addr[1:0]);
    // Full-word stores need no old data, so only loads and sub-word stores read.
    assign rd_en   = Req_Valid && Req_Ready && !req_err
                     && !(Req_Write && (Req_Mem_Ctrl == MEM_WORD));
    assign mem_we  = (state_q == DMEM_WRITE) && RST_N;

    always_ff @(posedge CLK) begin
        if (rd_en) begin
            rd_word_q <= mem[Req_Addr[INDEX_W+1:2]];
        end
        if (mem_we) begin
            mem[idx_q] <= wword_q;
        end
    end

    dmem_byte_lane u_lane (
        .old_word    (rd_word_q),
        .store_data  (wword_q),
        .addr_lo     (lo_q),
        .mem_ctrl    (ctrl_q),
        .merged_word (merged_word),
        .load_word   (load_word)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        ctrl_d  = ctrl_q;
        lo_d    = lo_q;
        idx_d   = idx_q;
        wword_d = wword_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            DMEM_IDLE: begin
                if (Req_Valid) begin
                    write_d = Req_Write;
                    ctrl_d  = Req_Mem_Ctrl;
                    lo_d    = Req_Addr[1:0];
                    idx_d   = Req_Addr[INDEX_W+1:2];
                    wword_d = Req_WData;
                    rdata_d = 32'b0;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = DMEM_RESP;
                    end else if (Req_Write && (Req_Mem_Ctrl == MEM_WORD)) begin
                        state_d = DMEM_WRITE;
                    end else begin
                        state_d = DMEM_READ;
                    end
                end
            end
            DMEM_READ: begin
                if (write_q) begin
                    wword_d = merged_word;
                    state_d = DMEM_WRITE;
                end else begin
                    rdata_d = load_word;
                    state_d = DMEM_RESP;
                end
            end
            DMEM_WRITE: state_d = DMEM_RESP;
            DMEM_RESP:  state_d = DMEM_IDLE;
            default:    state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= DMEM_IDLE;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        write_q <= write_d;
        ctrl_q  <= ctrl_d;
        lo_q    <= lo_d;
        idx_q   <= idx_d;
        wword_q <= wword_d;
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Scoreboard bench for data_mem_controller: directed cases plus randomized
// traffic checked against a word-array reference model.
module tb_data_mem_controller;
    import data_mem_controller_pkg::*;

    localparam time T = 10;

    logic        clk = 1'b0;
    logic        RST_N;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [31:0] Req_Addr;
    logic [31:0] Req_WData;
    logic [2:0]  Req_Mem_Ctrl;
    logic        Resp_Valid;
    logic [31:0] Resp_RData;
    logic        Resp_Error;

    always #(T/2) clk = ~clk;

    data_mem_controller dut (
        .CLK          (clk),
        .RST_N        (RST_N),
        .Req_Valid    (Req_Valid),
        .Req_Ready    (Req_Ready),
        .Req_Write    (Req_Write),
        .Req_Addr     (Req_Addr),
        .Req_WData    (Req_WData),
        .Req_Mem_Ctrl (Req_Mem_Ctrl),
        .Resp_Valid   (Resp_Valid),
        .Resp_RData   (Resp_RData),
        .Resp_Error   (Resp_Error)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        time         t_acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [1024];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        prev_valid = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endfunction

    // Reference model: applies the request to the word array and returns the response.
    function automatic void predict(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                    input logic [2:0] c, output exp_t e);
        int          idx;
        int          lo;
        int          sh_h;
        logic [31:0] word;
        logic [31:0] sh;
        logic        bad;
        idx  = int'((a >> 2) % 1024);
        lo   = int'(a % 4);
        word = model[idx];
        bad  = (c == 3) || (c == 6) || (c == 7) || (w && c >= 4)
               || ((c == 1 || c == 5) && (lo % 2 == 1)) || (c == 2 && lo != 0);
        e.rdata = 32'b0;
        e.err   = bad;
        e.lat   = 1;
        e.t_acc = 0;
        if (!bad) begin
            if (w) begin
                sh_h = (lo / 2) * 16;
                if (c == 2) word = wd;
                else if (c == 0) word = (word & ~(32'hFF << (8*lo))) | ((wd & 32'hFF) << (8*lo));
                else word = (word & ~(32'hFFFF << sh_h)) | ((wd & 32'hFFFF) << sh_h);
                model[idx] = word;
                e.lat = (c == 2) ? 2 : 3;
            end else begin
                sh    = word >> (8*lo);
                e.lat = 2;
                case (c)
                    3'd0:    e.rdata = {{24{sh[7]}}, sh[7:0]};
                    3'd4:    e.rdata = {24'b0, sh[7:0]};
                    3'd1:    e.rdata = {{16{sh[15]}}, sh[15:0]};
                    3'd5:    e.rdata = {16'b0, sh[15:0]};
                    default: e.rdata = word;
                endcase
            end
        end
    endfunction

    // Waits for Ready (scrambling fields while busy), then presents the request.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] c, input bit expect_resp,
                         input bit use_exp, input logic [31:0] exp_rd);
        exp_t e;
        int   k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (Req_Ready) break;
            Req_Write    = 1'($urandom);
            Req_Addr     = $urandom;
            Req_WData    = $urandom;
            Req_Mem_Ctrl = 3'($urandom);
        end
        if (k == 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got Req_Ready=0 for 50 cycles required 1");
        end
        Req_Valid    = 1'b1;
        Req_Write    = w;
        Req_Addr     = a;
        Req_WData    = wd;
        Req_Mem_Ctrl = c;
        if (expect_resp) begin
            predict(w, a, wd, c, e);
            if (use_exp) e.rdata = exp_rd;
            e.t_acc = $time;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int k;
        @(negedge clk);
        Req_Valid = 1'b0;
        for (k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (k == 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending responses required 0", exp_q.size());
        end
    endtask

    task automatic dir(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] c, input logic [31:0] exp_rd);
        issue(w, a, wd, c, 1'b1, 1'b1, exp_rd);
        drain();
    endtask

    // Monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (Resp_Valid === 1'b1) begin
            check("resp_pulse_width", 32'(prev_valid), 32'd0);
            check("ready_low_in_resp", 32'(Req_Ready), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got Resp_Valid=1 rdata=0x%08h required no response", Resp_RData);
            end else begin
                e = exp_q.pop_front();
                $display("resp rdata=0x%08h err=%0d lat=%0d", Resp_RData, Resp_Error, int'(($time - e.t_acc) / T));
                check("resp_rdata", Resp_RData, e.rdata);
                check("resp_error", 32'(Resp_Error), 32'(e.err));
                check("resp_latency", 32'(int'(($time - e.t_acc) / T)), 32'(e.lat));
            end
        end
        prev_valid = Resp_Valid;
    end

    initial begin
        #(T * 60000);
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        RST_N        = 1'b0;
        Req_Valid    = 1'b0;
        Req_Write    = 1'b0;
        Req_Addr     = 32'b0;
        Req_WData    = 32'b0;
        Req_Mem_Ctrl = 3'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(Req_Ready), 32'd1);
        check("reset_resp_valid", 32'(Resp_Valid), 32'd0);
        check("reset_rdata", Resp_RData, 32'd0);
        check("reset_error", 32'(Resp_Error), 32'd0);
        RST_N = 1'b1;

        dir(1'b1, 32'h10, 32'h8899AABB, MEM_WORD, 32'h0);
        dir(1'b0, 32'h10, 32'h0, MEM_WORD, 32'h8899AABB);
        dir(1'b0, 32'h13, 32'h0, MEM_BYTE, 32'hFFFFFF88);
        dir(1'b0, 32'h13, 32'h0, MEM_BYTE_UNSIGNED, 32'h00000088);
        dir(1'b0, 32'h12, 32'h0, MEM_HALFWORD, 32'hFFFF8899);
        dir(1'b0, 32'h10, 32'h0, MEM_HALFWORD_UNSIGNED, 32'h0000AABB);
        dir(1'b1, 32'h11, 32'h12345677, MEM_BYTE, 32'h0);
        dir(1'b0, 32'h10, 32'h0, MEM_WORD, 32'h889977BB);
        dir(1'b0, 32'h12, 32'h0, MEM_WORD, 32'h0);
        dir(1'b1, 32'h13, 32'hFFFF, MEM_HALFWORD, 32'h0);
        dir(1'b0, 32'h10, 32'h0, 3'b011, 32'h0);
        dir(1'b0, 32'h10, 32'h0, MEM_WORD, 32'h889977BB);

        // Back-to-back with Req_Valid held high and fields scrambled while busy.
        issue(1'b0, 32'h10, 32'h0, MEM_WORD, 1'b1, 1'b1, 32'h889977BB);
        issue(1'b0, 32'h11, 32'h0, MEM_BYTE, 1'b1, 1'b1, 32'h00000077);
        issue(1'b1, 32'h20, 32'hCAFEF00D, MEM_WORD, 1'b1, 1'b0, 32'h0);
        issue(1'b0, 32'h22, 32'h0, MEM_HALFWORD_UNSIGNED, 1'b1, 1'b1, 32'h0000CAFE);
        drain();

        // Reset while the sub-word store is in WRITE: no write, no response.
        issue(1'b1, 32'h10, 32'hFF, MEM_BYTE, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        Req_Valid = 1'b0;
        @(negedge clk);
        RST_N = 1'b0;
        @(negedge clk);
        RST_N = 1'b1;
        check("ready_after_reset", 32'(Req_Ready), 32'd1);
        check("no_resp_after_reset", 32'(Resp_Valid), 32'd0);
        repeat (3) @(negedge clk);
        dir(1'b0, 32'h10, 32'h0, MEM_WORD, 32'h889977BB);

        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 32'(i) << 2, $urandom, MEM_WORD, 1'b1, 1'b0, 32'h0);
            drain();
        end
        for (int i = 0; i < 200; i++) begin
            a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            issue(1'($urandom), a, $urandom, 3'($urandom), 1'b1, 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 0) drain();
        end
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
